// File: rtl/ram_writer_if.sv
// Bundles the load, dump, random-read and status signals of ram_writer.
// The master modport drives the block's inputs; the slave modport is the block itself.
interface ram_writer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              load_start;
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              dump_start;
    logic              dump_ready;
    logic              dump_valid;
    logic [ADDR_W-1:0] dump_addr;
    logic [DATA_W-1:0] dump_data;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W:0]   wr_count;
    logic              full;
    logic              busy;

    modport master (
        output load_start, wr_valid, wr_data, dump_start, dump_ready, rd_addr,
        input  wr_ready, dump_valid, dump_addr, dump_data, rd_data, wr_count, full, busy
    );

    modport slave (
        input  load_start, wr_valid, wr_data, dump_start, dump_ready, rd_addr,
        output wr_ready, dump_valid, dump_addr, dump_data, rd_data, wr_count, full, busy
    );
endinterface

// File: rtl/ram_writer.sv
// Loads a stream of words into a small register array, then streams the stored
// entries back out with ready/valid backpressure; a separate registered read port is always live.
module ram_writer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic         clk,
    input  logic         rst,
    ram_writer_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE  = 1;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_FULL, ST_DUMP} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] dump_ptr_q, dump_ptr_d;
    logic [ADDR_W:0]   wr_count_q, wr_count_d;
    logic [ADDR_W:0]   wr_count_inc;
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              mem_we;
    logic              last_beat;

    assign wr_count_inc = wr_count_q + CNT_ONE;
    assign last_beat    = ({1'b0, dump_ptr_q} == (wr_count_q - CNT_ONE));

    // NOTE: every output of this block is assigned a default first, so no path can infer a latch.
    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        dump_ptr_d     = dump_ptr_q;
        wr_count_d     = wr_count_q;
        mem_we         = 1'b0;
        bus.wr_ready   = 1'b0;
        bus.dump_valid = 1'b0;
        bus.dump_addr  = '0;
        bus.dump_data  = '0;

        unique case (state_q)
            ST_IDLE, ST_FULL: begin
                if (bus.load_start) begin
                    state_d    = ST_LOAD;
                    wr_ptr_d   = '0;
                    wr_count_d = '0;
                end else if (bus.dump_start && (wr_count_q != '0)) begin
                    state_d    = ST_DUMP;
                    dump_ptr_d = '0;
                end
            end
            ST_LOAD: begin
                bus.wr_ready = !bus.load_start;
                if (bus.load_start) begin
                    wr_ptr_d   = '0;
                    wr_count_d = '0;
                end else begin
                    if (bus.wr_valid) begin
                        mem_we     = 1'b1;
                        wr_ptr_d   = wr_ptr_q + PTR_ONE;
                        wr_count_d = wr_count_inc;
                        if (wr_count_inc == CNT_FULL) state_d = ST_FULL;
                    end
                    // A write in the same cycle as dump_start is kept and becomes part of the dump.
                    if (bus.dump_start) begin
                        dump_ptr_d = '0;
                        state_d    = (wr_count_d != '0) ? ST_DUMP : ST_IDLE;
                    end
                end
            end
            ST_DUMP: begin
                bus.dump_valid = 1'b1;
                bus.dump_addr  = dump_ptr_q;
                bus.dump_data  = mem_q[dump_ptr_q];
                if (bus.dump_ready) begin
                    if (last_beat) begin
                        dump_ptr_d = '0;
                        state_d    = wr_count_q[ADDR_W] ? ST_FULL : ST_IDLE;
                    end else begin
                        dump_ptr_d = dump_ptr_q + PTR_ONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            dump_ptr_q <= '0;
            wr_count_q <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            dump_ptr_q <= dump_ptr_d;
            wr_count_q <= wr_count_d;
            rd_data_q  <= mem_q[bus.rd_addr];
        end
    end

    // NOTE: the array is deliberately left out of reset; contents survive rst, only writes are blocked.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) mem_q[wr_ptr_q] <= bus.wr_data;
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.wr_count = wr_count_q;
    assign bus.full     = (state_q == ST_FULL);
    assign bus.busy     = (state_q == ST_LOAD) || (state_q == ST_DUMP);
endmodule

// File: tb/tb_ram_writer.sv
// Self-checking bench for ram_writer: directed load/dump/read scenarios followed by
// random traffic, all compared every cycle against a behavioural model of the store.
module tb_ram_writer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_writer_if #(.DATA_W(8), .ADDR_W(4)) bus ();

    ram_writer #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: contents, how many entries the current load holds, and what the block is doing.
    logic [7:0] m_mem   [16];
    bit         m_known [16];
    int         m_count   = 0;
    bit         m_loading = 0;
    bit         m_dumping = 0;
    int         m_idx     = 0;
    logic [7:0] m_rd      = '0;
    bit         m_rd_known = 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("wr_ready", 32'(bus.wr_ready), 32'(m_loading && !bus.load_start));
        check("dump_valid", 32'(bus.dump_valid), 32'(m_dumping));
        check("dump_addr", 32'(bus.dump_addr), m_dumping ? 32'(m_idx) : 32'd0);
        if (!m_dumping) check("dump_data_idle", 32'(bus.dump_data), 32'd0);
        else if (m_known[m_idx]) check("dump_data", 32'(bus.dump_data), 32'(m_mem[m_idx]));
        check("full", 32'(bus.full), 32'(!m_loading && !m_dumping && m_count == 16));
        check("busy", 32'(bus.busy), 32'(m_loading || m_dumping));
        check("wr_count", 32'(bus.wr_count), 32'(m_count));
        if (m_rd_known) check("rd_data", 32'(bus.rd_data), 32'(m_rd));
    endtask

    // Applies the rules for one rising edge using the inputs presented before it.
    task automatic model_step();
        logic [7:0] nrd;
        bit         nknown;
        if (rst) begin
            m_loading = 0; m_dumping = 0; m_count = 0; m_idx = 0;
            m_rd = '0; m_rd_known = 1;
            return;
        end
        nrd    = m_mem[bus.rd_addr];
        nknown = m_known[bus.rd_addr];
        if (m_dumping) begin
            if (bus.dump_ready) begin
                if (m_idx == m_count - 1) m_dumping = 0;
                else m_idx++;
            end
        end else if (bus.load_start) begin
            m_loading = 1;
            m_count   = 0;
        end else if (m_loading) begin
            if (bus.wr_valid) begin
                m_mem[m_count]   = bus.wr_data;
                m_known[m_count] = 1;
                m_count++;
                if (m_count == 16) m_loading = 0;
            end
            if (bus.dump_start) begin
                m_loading = 0;
                if (m_count > 0) begin m_dumping = 1; m_idx = 0; end
            end
        end else if (bus.dump_start && m_count > 0) begin
            m_dumping = 1;
            m_idx     = 0;
        end
        m_rd       = nrd;
        m_rd_known = nknown;
    endtask

    task automatic tick();
        #1;
        check_outputs();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic quiet_inputs();
        bus.load_start = 0; bus.wr_valid = 0; bus.wr_data = '0;
        bus.dump_start = 0; bus.dump_ready = 0;
    endtask

    task automatic do_load(input int n, input logic [7:0] base);
        bus.load_start = 1; tick(); bus.load_start = 0;
        for (int i = 0; i < n; i++) begin
            bus.wr_valid = 1;
            bus.wr_data  = base + 8'(i);
            tick();
        end
        bus.wr_valid = 0;
    endtask

    initial begin
        int         beats;
        bit         stalled;
        logic [3:0] held_a;
        logic [7:0] held_d;

        quiet_inputs();
        bus.rd_addr = '0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        check("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
        check("rst_full", 32'(bus.full), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_dump_valid", 32'(bus.dump_valid), 32'd0);
        check("rst_wr_count", 32'(bus.wr_count), 32'd0);
        check("rst_rd_data", 32'(bus.rd_data), 32'd0);

        // Fill all sixteen entries.
        do_load(16, 8'h10);
        check("fill_count", 32'(bus.wr_count), 32'd16);
        check("fill_full", 32'(bus.full), 32'd1);
        check("fill_wr_ready", 32'(bus.wr_ready), 32'd0);
        tick();

        // Dump with dump_ready alternating 1/0.
        bus.dump_start = 1; tick(); bus.dump_start = 0;
        beats = 0; stalled = 0; held_a = '0; held_d = '0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            bus.dump_ready = (cyc % 2 == 0);
            #1;
            if (!bus.dump_valid) break;
            if (stalled) begin
                check("hold_addr", 32'(bus.dump_addr), 32'(held_a));
                check("hold_data", 32'(bus.dump_data), 32'(held_d));
            end
            if (bus.dump_ready) begin
                check("beat_addr", 32'(bus.dump_addr), 32'(beats));
                check("beat_data", 32'(bus.dump_data), 32'h10 + 32'(beats));
                beats++;
                stalled = 0;
            end else begin
                stalled = 1;
                held_a  = bus.dump_addr;
                held_d  = bus.dump_data;
            end
            tick();
        end
        bus.dump_ready = 0;
        check("fill_beats", 32'(beats), 32'd16);
        check("dump_then_full", 32'(bus.full), 32'd1);
        check("dump_keeps_count", 32'(bus.wr_count), 32'd16);

        // Registered random-access read.
        bus.rd_addr = 4'd7; tick();
        check("rd_addr7", 32'(bus.rd_data), 32'h17);

        // Partial load of five entries, then dump.
        do_load(5, 8'hA0);
        bus.dump_start = 1; tick(); bus.dump_start = 0;
        bus.dump_ready = 1;
        beats = 0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            #1;
            if (!bus.dump_valid) break;
            check("part_data", 32'(bus.dump_data), 32'hA0 + 32'(beats));
            beats++;
            tick();
        end
        bus.dump_ready = 0;
        check("part_beats", 32'(beats), 32'd5);
        check("part_count", 32'(bus.wr_count), 32'd5);
        check("part_idle_busy", 32'(bus.busy), 32'd0);
        check("part_idle_full", 32'(bus.full), 32'd0);

        // Restart mid-load: the 0xEE presented with load_start must be dropped.
        do_load(3, 8'h30);
        bus.load_start = 1; bus.wr_valid = 1; bus.wr_data = 8'hEE; tick();
        bus.load_start = 0;
        check("restart_count", 32'(bus.wr_count), 32'd0);
        bus.wr_data = 8'h55; tick();
        check("restart_count1", 32'(bus.wr_count), 32'd1);
        bus.wr_data = 8'h66; tick();
        bus.rd_addr = 4'd2; bus.wr_data = 8'h77; tick();
        check("rd_old_value", 32'(bus.rd_data), 32'h32);
        bus.wr_valid = 0; tick();
        check("rd_new_value", 32'(bus.rd_data), 32'h77);
        bus.rd_addr = 4'd0; tick();
        check("restart_addr0", 32'(bus.rd_data), 32'h55);
        bus.rd_addr = 4'd3; tick();
        check("ee_not_written", 32'(bus.rd_data), 32'hA3);

        // Reset while the fourth beat is on the bus.
        do_load(16, 8'h10);
        bus.dump_start = 1; tick(); bus.dump_start = 0;
        bus.dump_ready = 1;
        beats = 0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            #1;
            if (!bus.dump_valid) break;
            if (bus.dump_addr == 4'd3) begin
                rst = 1; tick(); rst = 0;
                break;
            end
            beats++;
            tick();
        end
        bus.dump_ready = 0;
        check("rst_at_beat", 32'(beats), 32'd3);
        check("rst_dump_valid_after", 32'(bus.dump_valid), 32'd0);
        check("rst_count_after", 32'(bus.wr_count), 32'd0);
        bus.rd_addr = 4'd0; tick();
        check("mem_survives_rst", 32'(bus.rd_data), 32'h10);

        // Random traffic against the model.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst            = ($urandom_range(0, 99) == 0);
            bus.load_start = ($urandom_range(0, 19) == 0);
            bus.dump_start = ($urandom_range(0, 11) == 0);
            bus.wr_valid   = ($urandom_range(0, 9) < 7);
            bus.wr_data    = 8'($urandom);
            bus.dump_ready = ($urandom_range(0, 2) != 0);
            bus.rd_addr    = 4'($urandom);
            tick();
        end
        rst = 0;
        quiet_inputs();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
